// File: rtl/if_fetch_unit_pkg.sv
// Shared definitions for the instruction-fetch stage: reset defaults, FSM
// encodings and the debug view of the fetch controller.
package if_fetch_unit_pkg;

  localparam logic [31:0] DEF_RESET_PC = 32'h0000_3000;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0000;

  typedef enum logic {
    ST_REQ  = 1'b0,
    ST_HOLD = 1'b1
  } fetch_state_e;

  typedef struct packed {
    fetch_state_e state;
    logic         pend;
  } fetch_dbg_t;

  function automatic logic [31:0] pc_plus(input logic [31:0] pc, input logic [31:0] off);
    return pc + off;
  endfunction

endpackage

// File: rtl/if_pc_next.sv
// Next-PC selection: a pending or freshly accepted redirect target wins,
// otherwise sequential fetch.
module if_pc_next
  import if_fetch_unit_pkg::*;
(
  input  logic [31:0] pc,
  input  logic        pend,
  input  logic [31:0] target,
  input  logic        redirect_accept,
  output logic [31:0] next_pc
);

  assign next_pc = (pend || redirect_accept) ? target : pc_plus(pc, 32'd4);

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage with a one-entry skid buffer, delay-slot redirect
// handling and the IF/ID pipeline register.
module if_fetch_unit
  import if_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEF_RESET_PC,
  parameter logic [31:0] NOP_INST = DEF_NOP_INST
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        im_req,
  output logic [31:0] im_addr,
  input  logic        im_ack,
  input  logic [31:0] im_rdata,
  output logic [31:0] IF_ID_Inst,
  output logic [31:0] IF_ID_PC,
  output logic [31:0] IF_ID_PC8,
  output logic        IF_ID_valid,
  output logic        IF_ID_misalign,
  output fetch_dbg_t  dbg
);

  // Handshake: a fetch request is open while im_req=1; it completes in the
  // cycle im_ack=1, and im_rdata is consumed in that same cycle.
  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, target_q, skid_q;
  logic         pend_q;
  logic         misalign, fetch_done, redirect_accept, advance;
  logic [31:0]  fetch_word, target_sel, next_pc;

  // A misaligned address never waits on memory; it retires as a NOP.
  assign misalign        = |pc_q[1:0];
  assign fetch_done      = im_ack || misalign;
  assign fetch_word      = misalign ? NOP_INST : im_rdata;
  assign redirect_accept = redirect && !stall;
  assign target_sel      = redirect_accept ? redirect_pc : target_q;
  assign advance         = !stall && ((state_q == ST_REQ && fetch_done) || state_q == ST_HOLD);
  assign im_addr         = pc_q;
  assign dbg             = '{state: state_q, pend: pend_q};

  if_pc_next u_pc_next (
    .pc              (pc_q),
    .pend            (pend_q),
    .target          (target_sel),
    .redirect_accept (redirect_accept),
    .next_pc         (next_pc)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= ST_REQ;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_REQ:  if (fetch_done && stall) state_d = ST_HOLD;
      ST_HOLD: if (!stall)              state_d = ST_REQ;
      default:                          state_d = ST_REQ;
    endcase
  end

  always_comb begin
    im_req = (state_q == ST_REQ);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q           <= RESET_PC;
      pend_q         <= 1'b0;
      target_q       <= '0;
      skid_q         <= '0;
      IF_ID_Inst     <= NOP_INST;
      IF_ID_PC       <= '0;
      IF_ID_PC8      <= '0;
      IF_ID_valid    <= 1'b0;
      IF_ID_misalign <= 1'b0;
    end else begin
      if (advance) begin
        pc_q           <= next_pc;
        pend_q         <= 1'b0;
        IF_ID_Inst     <= (state_q == ST_HOLD) ? skid_q : fetch_word;
        IF_ID_PC       <= pc_q;
        IF_ID_PC8      <= pc_plus(pc_q, 32'd8);
        IF_ID_valid    <= 1'b1;
        IF_ID_misalign <= misalign;
      end else if (!stall && state_q == ST_REQ) begin
        // Delay-slot fetch still outstanding: bubble and remember the target.
        IF_ID_Inst     <= NOP_INST;
        IF_ID_valid    <= 1'b0;
        IF_ID_misalign <= 1'b0;
        if (redirect) begin
          target_q <= redirect_pc;
          pend_q   <= 1'b1;
        end
      end
      if (state_q == ST_REQ && fetch_done && stall) skid_q <= fetch_word;
    end
  end

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: stimulus pushes the expected IF/ID word
// into a queue, and a monitor compares it one cycle later.
module tb_if_fetch_unit;
  import if_fetch_unit_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0000;
  localparam int K_HOLD = 0;
  localparam int K_DEL  = 1;
  localparam int K_BUB  = 2;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        stall = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        im_req;
  logic [31:0] im_addr;
  logic        ack_drv = 1'b0;
  logic        im_ack;
  logic [31:0] im_rdata;
  logic [31:0] IF_ID_Inst, IF_ID_PC, IF_ID_PC8;
  logic        IF_ID_valid, IF_ID_misalign;
  fetch_dbg_t  dbg;

  logic [97:0] exp_q[$];
  logic [97:0] cur_exp;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  function automatic logic [97:0] pack(input logic v, input logic m, input logic [31:0] pc,
                                       input logic [31:0] pc8, input logic [31:0] inst);
    return {v, m, pc, pc8, inst};
  endfunction

  // Garbage on the data bus when no ack, so a skid-buffer miss is visible.
  assign im_ack   = ack_drv;
  assign im_rdata = ack_drv ? mem_word(im_addr) : 32'hDEAD_BEEF;

  if_fetch_unit dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .im_req         (im_req),
    .im_addr        (im_addr),
    .im_ack         (im_ack),
    .im_rdata       (im_rdata),
    .IF_ID_Inst     (IF_ID_Inst),
    .IF_ID_PC       (IF_ID_PC),
    .IF_ID_PC8      (IF_ID_PC8),
    .IF_ID_valid    (IF_ID_valid),
    .IF_ID_misalign (IF_ID_misalign),
    .dbg            (dbg)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: one expected IF/ID word per driven cycle.
  initial begin
    logic [97:0] e, a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = pack(IF_ID_valid, IF_ID_misalign, IF_ID_PC, IF_ID_PC8, IF_ID_Inst);
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL ifid @%0t: got v=%0b m=%0b pc=%h pc8=%h inst=%h expected v=%0b m=%0b pc=%h pc8=%h inst=%h",
                   $time, a[97], a[96], a[95:64], a[63:32], a[31:0],
                   e[97], e[96], e[95:64], e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic step(input logic ack, input logic stl, input logic rdr, input logic [31:0] rpc,
                      input int kind, input logic [31:0] epc);
    @(negedge clk);
    ack_drv     = ack;
    stall       = stl;
    redirect    = rdr;
    redirect_pc = rpc;
    case (kind)
      K_DEL: cur_exp = pack(1'b1, |epc[1:0], epc, epc + 32'd8, (|epc[1:0]) ? NOP : mem_word(epc));
      K_BUB: begin
        cur_exp[97]   = 1'b0;
        cur_exp[96]   = 1'b0;
        cur_exp[31:0] = NOP;
      end
      default: ;
    endcase
    exp_q.push_back(cur_exp);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n  = 1'b0;
    ack_drv  = 1'b0;
    stall    = 1'b0;
    redirect = 1'b0;
    exp_q.delete();
    cur_exp  = pack(1'b0, 1'b0, 32'h0, 32'h0, NOP);
    #1;
    chk("rst_inst",  IF_ID_Inst, NOP);
    chk("rst_pc",    IF_ID_PC, 32'h0);
    chk("rst_pc8",   IF_ID_PC8, 32'h0);
    chk("rst_valid", {31'b0, IF_ID_valid}, 32'h0);
    chk("rst_mis",   {31'b0, IF_ID_misalign}, 32'h0);
    chk("rst_addr",  im_addr, 32'h0000_3000);
    chk("rst_req",   {31'b0, im_req}, 32'h1);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic run_seq(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 32'h0, K_DEL, first + 32'(4 * i));
  endtask

  initial begin
    // Streaming, one per cycle
    do_reset();
    run_seq(32'h3000, 4);

    // Two-cycle memory wait at 3004
    do_reset();
    run_seq(32'h3000, 1);
    step(1'b0, 1'b0, 1'b0, 32'h0, K_BUB, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, K_BUB, 32'h0);
    run_seq(32'h3004, 2);

    // Stall with ack at 3008: HOLD, then release delivers the buffered word
    do_reset();
    run_seq(32'h3000, 2);
    step(1'b1, 1'b1, 1'b0, 32'h0, K_HOLD, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, K_HOLD, 32'h0);
    chk("hold_state", {31'b0, dbg.state}, {31'b0, ST_HOLD});
    chk("hold_req",   {31'b0, im_req}, 32'h0);
    step(1'b0, 1'b1, 1'b0, 32'h0, K_HOLD, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, K_DEL, 32'h3008);
    step(1'b1, 1'b0, 1'b0, 32'h0, K_DEL, 32'h300C);

    // Same-cycle redirect, then misaligned target and PC wraparound
    do_reset();
    run_seq(32'h3000, 5);
    step(1'b1, 1'b0, 1'b1, 32'h3100, K_DEL, 32'h3014);
    step(1'b1, 1'b0, 1'b0, 32'h0, K_DEL, 32'h3100);
    step(1'b1, 1'b0, 1'b1, 32'h3102, K_DEL, 32'h3104);
    step(1'b1, 1'b0, 1'b0, 32'h0, K_DEL, 32'h3102);
    step(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC, K_DEL, 32'h3106);
    step(1'b1, 1'b0, 1'b0, 32'h0, K_DEL, 32'hFFFF_FFFC);
    step(1'b1, 1'b0, 1'b0, 32'h0, K_DEL, 32'h0000_0000);

    // Delay-slot ack delayed two cycles: pend set, 3014 then 3100
    do_reset();
    run_seq(32'h3000, 5);
    step(1'b0, 1'b0, 1'b1, 32'h3100, K_BUB, 32'h0);
    step(1'b0, 1'b0, 1'b0, 32'h0, K_BUB, 32'h0);
    chk("pend_set", {31'b0, dbg.pend}, 32'h1);
    step(1'b1, 1'b0, 1'b0, 32'h0, K_DEL, 32'h3014);
    step(1'b1, 1'b0, 1'b0, 32'h0, K_DEL, 32'h3100);
    chk("pend_clr", {31'b0, dbg.pend}, 32'h0);

    // Second redirect while pending overwrites the target
    do_reset();
    run_seq(32'h3000, 5);
    step(1'b0, 1'b0, 1'b1, 32'h3100, K_BUB, 32'h0);
    step(1'b0, 1'b0, 1'b1, 32'h3200, K_BUB, 32'h0);
    step(1'b1, 1'b0, 1'b0, 32'h0, K_DEL, 32'h3014);
    step(1'b1, 1'b0, 1'b0, 32'h0, K_DEL, 32'h3200);

    // Reset pulsed during HOLD
    do_reset();
    run_seq(32'h3000, 1);
    step(1'b1, 1'b1, 1'b0, 32'h0, K_HOLD, 32'h0);
    step(1'b1, 1'b1, 1'b0, 32'h0, K_HOLD, 32'h0);
    chk("hold2_state", {31'b0, dbg.state}, {31'b0, ST_HOLD});
    @(posedge clk);
    #2;
    do_reset();
    chk("post_rst_state", {31'b0, dbg.state}, {31'b0, ST_REQ});
    run_seq(32'h3000, 2);

    @(posedge clk);
    #2;
    chk("queue_drained", exp_q.size(), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
